// File: rtl/seq_miter_monitor.sv
// Runtime miter monitor: compares golden/revised output vectors after a warm-up window.
// Optional MITER_ERRCNT_EN: count all mismatches over the full window and expose ERR_COUNT.
module seq_miter_monitor #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WARMUP = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             IN_VALID,
  input  logic [0:WIDTH-1] OUT_A,
  input  logic [0:WIDTH-1] OUT_B,
  output logic             BUSY,
  output logic             DONE,
  output logic             EQUIV,
  output logic [CNT_W-1:0] MISMATCH_IDX,
`ifdef MITER_ERRCNT_EN
  output logic [CNT_W-1:0] ERR_COUNT,
`endif
  output logic [0:WIDTH-1] MISMATCH_VEC
);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_CHECK, S_DONE} state_t;

  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP == 0 ? 0 : WARMUP - 1);
  localparam logic [CNT_W-1:0] DEPTH_LAST = CNT_W'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   warm_q, warm_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic               busy_d, done_d, equiv_d;
  logic [CNT_W-1:0]   idx_d;
  logic [0:WIDTH-1]   vec_d;
  logic               mismatch;
`ifdef MITER_ERRCNT_EN
  logic [CNT_W-1:0]   err_q, err_d;
  assign ERR_COUNT = err_q;
`endif

  assign mismatch = (OUT_A != OUT_B);

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    chk_d   = chk_q;
    equiv_d = EQUIV;
    idx_d   = MISMATCH_IDX;
    vec_d   = MISMATCH_VEC;
`ifdef MITER_ERRCNT_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          warm_d  = '0;
          chk_d   = '0;
          equiv_d = 1'b0;
          idx_d   = '0;
          vec_d   = '0;
`ifdef MITER_ERRCNT_EN
          err_d   = '0;
`endif
          state_d = (WARMUP == 0) ? S_CHECK : S_WARM;
        end
      end
      S_WARM: begin
        if (IN_VALID) begin
          warm_d = warm_q + 1'b1;
          if (warm_q == WARM_LAST) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (IN_VALID) begin
`ifdef MITER_ERRCNT_EN
          // first mismatch is the one seen while the error count is still zero
          if (mismatch) begin
            if (err_q == '0) begin
              idx_d = chk_q;
              vec_d = OUT_A ^ OUT_B;
            end
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          if (chk_q == DEPTH_LAST) begin
            equiv_d = (err_d == '0);
            state_d = S_DONE;
          end else begin
            chk_d = chk_q + 1'b1;
          end
`else
          if (mismatch) begin
            idx_d   = chk_q;
            vec_d   = OUT_A ^ OUT_B;
            equiv_d = 1'b0;
            state_d = S_DONE;
          end else if (chk_q == DEPTH_LAST) begin
            equiv_d = 1'b1;
            state_d = S_DONE;
          end else begin
            chk_d = chk_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_WARM) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      warm_q       <= '0;
      chk_q        <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      EQUIV        <= 1'b0;
      MISMATCH_IDX <= '0;
      MISMATCH_VEC <= '0;
`ifdef MITER_ERRCNT_EN
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      warm_q       <= warm_d;
      chk_q        <= chk_d;
      BUSY         <= busy_d;
      DONE         <= done_d;
      EQUIV        <= equiv_d;
      MISMATCH_IDX <= idx_d;
      MISMATCH_VEC <= vec_d;
`ifdef MITER_ERRCNT_EN
      err_q        <= err_d;
`endif
    end
  end

endmodule
